// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr_pkg
// Brief    : Shared constants and width helper for the stream_mux_rr block.
// Revision : 1.0 - initial release
// ============================================================================
package stream_mux_rr_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int STREAM_MUX_DEFAULT_BURST = 4;

   // Channel index width, never narrower than one bit.
   function automatic int chan_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr_if
// Brief    : N-channel input stream bundle plus the single output stream.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_mux_rr_if
   import stream_mux_rr_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 4
);
   localparam int CHANNEL_BITS = chan_bits(NUM_CHANNELS);

   logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data;
   logic [NUM_CHANNELS-1:0]            in_data_available;
   logic [NUM_CHANNELS-1:0]            in_data_ready;
   logic                               receiver_ready;
   logic [DATA_WIDTH-1:0]              out_data;
   logic                               out_data_available;
   logic [CHANNEL_BITS-1:0]            out_channel;

   modport master (
      output in_data, in_data_available, receiver_ready,
      input  in_data_ready, out_data, out_data_available, out_channel
   );

   modport slave (
      input  in_data, in_data_available, receiver_ready,
      output in_data_ready, out_data, out_data_available, out_channel
   );

endinterface
`default_nettype wire

// File: rtl/stream_mux_rr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; searches from pointer+1 upward.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import stream_mux_rr_pkg::*;
#(
   parameter  int NUM_CHANNELS = 4,
   localparam int CHANNEL_BITS = chan_bits(NUM_CHANNELS)
) (
   input  wire logic [NUM_CHANNELS-1:0] i_request,
   input  wire logic [CHANNEL_BITS-1:0] i_pointer,
   output logic      [NUM_CHANNELS-1:0] o_grant,
   output logic      [CHANNEL_BITS-1:0] o_grant_index,
   output logic                         o_any_grant
);

   // One spare bit so pointer+offset never overflows before the wrap compare.
   typedef logic [CHANNEL_BITS:0] cand_t;

   localparam cand_t c_num_channels = cand_t'(NUM_CHANNELS);

   cand_t w_cand;

   always_comb begin
      o_grant       = '0;
      o_grant_index = '0;
      o_any_grant   = FALSE;
      w_cand        = '0;
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
         w_cand = {1'b0, i_pointer} + cand_t'(i);
         if (w_cand >= c_num_channels) begin
            w_cand = w_cand - c_num_channels;
         end
         if (!o_any_grant && i_request[w_cand[CHANNEL_BITS-1:0]]) begin
            o_any_grant   = TRUE;
            o_grant_index = w_cand[CHANNEL_BITS-1:0];
         end
      end
      o_grant[o_grant_index] = o_any_grant;
   end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Brief    : Round-robin N-to-1 stream mux with a one-word registered output.
//            Define STREAM_MUX_BURST_EN to allow up to MAX_BURST words per grant.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int MAX_BURST    = STREAM_MUX_DEFAULT_BURST
) (
   input wire logic     clk,
   input wire logic     reset,
   stream_mux_rr_if.slave bus
);

   localparam int CHANNEL_BITS = chan_bits(NUM_CHANNELS);
   localparam logic [CHANNEL_BITS-1:0] c_last_channel = CHANNEL_BITS'(NUM_CHANNELS - 1);

   if (NUM_CHANNELS < 2 || MAX_BURST < 1) begin : g_bad_params
      $error("stream_mux_rr: NUM_CHANNELS must be >= 2 and MAX_BURST >= 1");
   end

   logic [DATA_WIDTH-1:0]   w_words [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] w_grant;
   logic [CHANNEL_BITS-1:0] w_grant_index;
   logic                    w_any_grant;
   logic                    w_slot_free;
   logic                    w_accept;

   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [CHANNEL_BITS-1:0] r_out_channel;
   logic                    r_out_valid;
   logic [CHANNEL_BITS-1:0] r_last_grant;

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
      assign w_words[g] = bus.in_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_arbiter (
      .i_request     (bus.in_data_available),
      .i_pointer     (r_last_grant),
      .o_grant       (w_grant),
      .o_grant_index (w_grant_index),
      .o_any_grant   (w_any_grant)
   );

   // The output register can take a word when empty or being drained this cycle.
   assign w_slot_free = ~r_out_valid | bus.receiver_ready;
   assign w_accept    = w_any_grant & w_slot_free & ~reset;

   assign bus.in_data_ready      = w_accept ? w_grant : '0;
   assign bus.out_data           = r_out_data;
   assign bus.out_data_available = r_out_valid;
   assign bus.out_channel        = r_out_channel;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_data    <= '0;
         r_out_channel <= '0;
         r_out_valid   <= FALSE;
      end else if (w_accept) begin
         r_out_data    <= w_words[w_grant_index];
         r_out_channel <= w_grant_index;
         r_out_valid   <= TRUE;
      end else if (r_out_valid && bus.receiver_ready) begin
         r_out_valid   <= FALSE;
      end
   end

`ifdef STREAM_MUX_BURST_EN
   localparam int BURST_BITS = $clog2(MAX_BURST + 1);

   logic [BURST_BITS-1:0]   r_burst_count;
   logic [BURST_BITS-1:0]   w_base_count;
   logic [CHANNEL_BITS-1:0] w_held;
   logic [CHANNEL_BITS-1:0] w_before_grant;
   logic                    w_burst_more;

   // w_held is the channel searched first; pointing one below g keeps g on top.
   always_comb begin
      w_held         = (r_last_grant == c_last_channel) ? '0 : r_last_grant + 1'b1;
      w_before_grant = (w_grant_index == '0) ? c_last_channel : w_grant_index - 1'b1;
      w_base_count   = '0;
      if (w_grant_index == w_held && r_burst_count != '0) begin
         w_base_count = r_burst_count;
      end
      w_burst_more   = (int'(w_base_count) + 1) < MAX_BURST;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant  <= c_last_channel;
         r_burst_count <= '0;
      end else if (w_accept) begin
         if (w_burst_more) begin
            r_last_grant  <= w_before_grant;
            r_burst_count <= w_base_count + 1'b1;
         end else begin
            r_last_grant  <= w_grant_index;
            r_burst_count <= '0;
         end
      end else if (r_burst_count != '0 && !bus.in_data_available[w_held]) begin
         r_last_grant  <= w_held;
         r_burst_count <= '0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= c_last_channel;
      end else if (w_accept) begin
         r_last_grant <= w_grant_index;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Brief    : Directed self-checking bench for stream_mux_rr (4- and 3-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

   logic clk = 1'b0;
   logic reset;

   stream_mux_rr_if #(.DATA_WIDTH(8), .NUM_CHANNELS(4)) if4 ();
   stream_mux_rr_if #(.DATA_WIDTH(8), .NUM_CHANNELS(3)) if3 ();

   stream_mux_rr #(.DATA_WIDTH(8), .NUM_CHANNELS(4), .MAX_BURST(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4.slave)
   );

   stream_mux_rr #(.DATA_WIDTH(8), .NUM_CHANNELS(3), .MAX_BURST(4)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (if3.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] data4 [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive4();
      for (int i = 0; i < 4; i++) if4.in_data[i*8 +: 8] = data4[i];
   endtask

   // One clock: a producer whose word was taken advances to its next word.
   task automatic step4();
      logic [3:0] acc;
      @(negedge clk);
      acc = if4.in_data_ready & if4.in_data_available;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i]) data4[i] = data4[i] + 8'd1;
      drive4();
   endtask

   int cnt3 [3];
`ifdef STREAM_MUX_BURST_EN
   int exp_burst [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
`endif

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) data4[i] = 8'h00;
      drive4();
      if4.in_data_available = '0;
      if4.receiver_ready    = 1'b0;
      if3.in_data           = '0;
      if3.in_data_available = '0;
      if3.receiver_ready    = 1'b0;
      repeat (2) step4();
      reset = 1'b0;
      #1;
      check("reset_valid", 32'(if4.out_data_available), 32'd0);
      check("reset_data", 32'(if4.out_data), 32'd0);
      check("reset_chan", 32'(if4.out_channel), 32'd0);
      check("reset_ready", 32'(if4.in_data_ready), 32'd0);

`ifndef STREAM_MUX_BURST_EN
      // All four saturated: strict rotation starting at channel 0.
      for (int i = 0; i < 4; i++) data4[i] = 8'h10 + 8'(i);
      drive4();
      if4.in_data_available = 4'hF;
      if4.receiver_ready    = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rot_ready", 32'(if4.in_data_ready), 32'(1 << (k % 4)));
         step4();
         check("rot_valid", 32'(if4.out_data_available), 32'd1);
         check("rot_chan", 32'(if4.out_channel), 32'(k % 4));
         check("rot_data", 32'(if4.out_data), 32'(8'h10 + 8'(k % 4) + 8'(k / 4)));
      end
      if4.in_data_available = '0;
      step4();
      check("drain_valid", 32'(if4.out_data_available), 32'd0);
`else
      // Burst mode: up to four words per grant, early switch when the owner drops.
      for (int i = 0; i < 4; i++) data4[i] = 8'h10 + 8'(i);
      drive4();
      if4.in_data_available = 4'b0011;
      if4.receiver_ready    = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step4();
         check("burst_chan", 32'(if4.out_channel), 32'(exp_burst[k]));
      end
      if4.in_data_available = 4'b0010;
      step4();
      check("burst_drop_chan", 32'(if4.out_channel), 32'd1);
      if4.in_data_available = '0;
      step4();
      check("burst_drain", 32'(if4.out_data_available), 32'd0);
`endif

      // Backpressure: channel 2 alone, receiver stalled for three cycles.
      data4[2] = 8'hA5;
      drive4();
      if4.in_data_available = 4'b0100;
      if4.receiver_ready    = 1'b0;
      #1;
      check("bp_ready_first", 32'(if4.in_data_ready), 32'h4);
      step4();
      check("bp_data", 32'(if4.out_data), 32'hA5);
      check("bp_chan", 32'(if4.out_channel), 32'd2);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_ready_held", 32'(if4.in_data_ready), 32'd0);
         step4();
         check("bp_data_held", 32'(if4.out_data), 32'hA5);
         check("bp_valid_held", 32'(if4.out_data_available), 32'd1);
      end
      if4.receiver_ready = 1'b1;
      #1;
      check("bp_ready_release", 32'(if4.in_data_ready), 32'h4);
      step4();
      check("bp_reload", 32'(if4.out_data), 32'hA6);
      if4.in_data_available = '0;
      step4();
      check("bp_drained", 32'(if4.out_data_available), 32'd0);
      check("bp_accepts", 32'(data4[2]), 32'hA7);

`ifndef STREAM_MUX_BURST_EN
      // Channels 1 and 3 only, with the pointer parked on channel 1.
      data4[1] = 8'h31;
      drive4();
      if4.in_data_available = 4'b0010;
      step4();
      check("pair_setup_chan", 32'(if4.out_channel), 32'd1);
      data4[3] = 8'h40;
      drive4();
      if4.in_data_available = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("pair_ready", 32'(if4.in_data_ready), (k % 2 == 0) ? 32'h8 : 32'h2);
         step4();
         check("pair_chan", 32'(if4.out_channel), (k % 2 == 0) ? 32'd3 : 32'd1);
      end
      if4.in_data_available = '0;
      step4();
`endif

      // Reset while a word is held: the word must vanish.
      data4[0] = 8'h77;
      drive4();
      if4.in_data_available = 4'b0001;
      if4.receiver_ready    = 1'b0;
      step4();
      check("rst_hold_data", 32'(if4.out_data), 32'h77);
      if4.in_data_available = 4'b0010;
      if4.receiver_ready    = 1'b1;
      reset = 1'b1;
      #1;
      check("rst_ready_zero", 32'(if4.in_data_ready), 32'd0);
      step4();
      check("rst_valid", 32'(if4.out_data_available), 32'd0);
      check("rst_chan", 32'(if4.out_channel), 32'd0);
      reset = 1'b0;
      if4.in_data_available = '0;
      for (int k = 0; k < 3; k++) begin
         step4();
         check("rst_no_deliver", 32'(if4.out_data_available), 32'd0);
      end

`ifndef STREAM_MUX_BURST_EN
      // Three channels: pointer wraps 2 -> 0, fair share over nine words.
      if3.in_data           = {8'h22, 8'h21, 8'h20};
      if3.in_data_available = 3'b111;
      if3.receiver_ready    = 1'b1;
      for (int i = 0; i < 3; i++) cnt3[i] = 0;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk);
         #1;
         check("n3_chan", 32'(if3.out_channel), 32'(k % 3));
         check("n3_data", 32'(if3.out_data), 32'(8'h20 + 8'(k % 3)));
         if (if3.out_channel < 2'd3) cnt3[if3.out_channel]++;
      end
      if3.in_data_available = '0;
      for (int i = 0; i < 3; i++) check("n3_count", 32'(cnt3[i]), 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-input stream multiplexer with round-robin fairness and a one-word registered output stage.
- Merges byte/word streams from several producers (e.g. serial RX, keyboard, internal generators) into one consumer using the available/ready handshake.
- Supports one-word-per-cycle throughput under continuous load and full backpressure from the receiver.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- NUM_CHANNELS, 4, number of input channels (>= 2).
- MAX_BURST, 4, maximum consecutive words per grant; used only when the burst feature is compiled in (>= 1).
- Derived localparam CHANNEL_BITS = max(1, $clog2(NUM_CHANNELS)).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_data  input  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_data_available  input  NUM_CHANNELS  per-channel valid.
- in_data_ready  output  NUM_CHANNELS  per-channel accept; one-hot or zero.
- receiver_ready  input  1  consumer can take out_data this cycle.
- out_data  output  DATA_WIDTH  registered output word.
- out_data_available  output  1  out_data valid.
- out_channel  output  CHANNEL_BITS  source channel of out_data.

Behaviour:
- Input transfer on channel i: in_data_available[i] & in_data_ready[i] at posedge. Output transfer: out_data_available & receiver_ready.
- Producers hold data stable while available=1 and not ready. Ready for a channel never rises without a grant.
- Pointer last_grant (CHANNEL_BITS) resets to NUM_CHANNELS-1, so channel 0 has first priority.
- Grant: combinational. Selects the first channel with available=1, searching from last_grant+1 upward and wrapping modulo NUM_CHANNELS. No grant if no channel is available.
- slot_free = ~out_data_available | receiver_ready.
- in_data_ready[g] = slot_free for the granted channel g; all other ready bits are 0.
- On an input transfer from g:
  - out_data <= word from g; out_channel <= g; out_data_available <= 1, all on the next edge. Latency is exactly 1 cycle.
  - last_grant <= g, unless held by the burst feature.
- Output transfer with no input transfer in the same cycle: out_data_available <= 0. out_data and out_channel hold their values.
- Simultaneous output transfer and input transfer: out_data_available stays 1 and the register is reloaded. This gives zero bubbles.
- Backpressure (out_data_available=1, receiver_ready=0): all ready bits are 0 and the register holds.
- Idle (no available): no state change other than draining.
- Reset values: out_data_available=0, out_data=0, out_channel=0, last_grant=NUM_CHANNELS-1, burst_count=0.
- Reset asserted mid-operation: any held word is dropped, and ready bits are 0 during the reset cycle.
- NUM_CHANNELS not a power of two: pointer wrap uses an explicit compare, never natural overflow.

Optional Feature:
- Macro STREAM_MUX_BURST_EN.
- Defined:
  - A burst_count register (width $clog2(MAX_BURST+1)) is added.
  - After an accepted word from g with burst_count+1 < MAX_BURST, last_grant is set so that g is searched first next cycle, and burst_count increments.
  - If g drops available, or burst_count+1 == MAX_BURST, last_grant <= g and burst_count <= 0, so rotation resumes.
  - MAX_BURST=1 behaves identically to the undefined case.
- Undefined: exactly one word per grant, then rotate. No burst_count logic or register is present.

Decomposition:
- Shared constant include (existing constant.v): TRUE/FALSE.
- Add STREAM_MUX_DEFAULT_BURST to the same include.
- Sub-module rr_arbiter(NUM_CHANNELS):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; reusable for other arbiters.

Test Plan:
- Reset then all four channels available continuously (ch i sends 8'h10+i, incrementing), receiver_ready=1:
  - out_channel sequence is 0,1,2,3,0,…
  - One word per cycle, first word 1 cycle after first accept.
- Only ch2 available (8'hA5), receiver_ready=0 for 3 cycles:
  - out_data=8'hA5 held.
  - in_data_ready=4'b0000 throughout.
  - Accepted exactly once after ready rises.
- Ch1 and ch3 requesting, last_grant=1:
  - Next grant is ch3, then ch1.
  - Ch0 and ch2 never get ready.
- Reset asserted while out_data_available=1:
  - Next cycle out_data_available=0, out_channel=0.
  - The held word is never delivered.
- NUM_CHANNELS=3, all requesting for 9 words:
  - Each channel gets exactly 3 words.
  - Pointer wraps 2→0 without an illegal index.
- STREAM_MUX_BURST_EN, MAX_BURST=4, ch0 and ch1 saturated:
  - Channel pattern is 0,0,0,0,1,1,1,1,0…
  - Ch0 dropping after 2 words switches to ch1 immediately.
